// File: rtl/rc5_pkg.sv
// rtl/rc5_pkg.sv - shared frame width, FSM states and named command codes for the RC5 receiver
package rc5_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_GAP
    } rc5_state_e;

    localparam logic [FRAME_BITS-1:0] RC5_CMD_A    = 11'b11000000111;
    localparam logic [FRAME_BITS-1:0] RC5_CMD_B    = 11'b11000000100;
    localparam logic [FRAME_BITS-1:0] RC5_CMD_C    = 11'b11000000000;
    localparam logic [FRAME_BITS-1:0] RC5_CMD_ZERO = 11'b00000000000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for the asynchronous serial line
module sync_2ff (
    input  logic clock,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give metastability a full cycle to settle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rc5_manchester_rx.sv
// rtl/rc5_manchester_rx.sv - Manchester frame receiver: start-bit lock, half-bit sampling, validity check
module rc5_manchester_rx #(
    parameter int HALF_BIT_CYCLES = 4,
    parameter int FRAME_BITS      = rc5_pkg::FRAME_BITS
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  s_in,
    output logic [FRAME_BITS-1:0] code,
    output logic                  valid,
    output logic                  err,
    output logic                  busy
);

    import rc5_pkg::*;

    localparam int T     = 2 * HALF_BIT_CYCLES;
    localparam int CNT_W = $clog2((FRAME_BITS + 1) * T + 1);
    localparam int GAP_W = $clog2(T + 1);
    localparam int IDX_W = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] START_CHK = CNT_W'(HALF_BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] FIRST_SMP = CNT_W'(T - HALF_BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] SMP_STEP  = CNT_W'(HALF_BIT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LEN   = GAP_W'(T);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(FRAME_BITS);

    logic                  s_sync;
    logic                  s_prev_q;
    logic                  rise;
    rc5_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      samp_q;
    logic                  half_q;
    logic                  a_q;
    logic [IDX_W-1:0]      idx_q;
    logic [GAP_W-1:0]      gap_q;
    logic [FRAME_BITS-2:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    logic [FRAME_BITS-1:0] code_q;
    logic                  valid_q;
    logic                  err_q;

    sync_2ff u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d_i   (s_in),
        .q_o   (s_sync)
    );

    // Previous synchronised level, for rising-edge detection.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= s_sync;
        end
    end

    assign rise = s_sync & ~s_prev_q;

    // Shift register with the current second-half sample appended as the new LSB.
    always_comb begin
        shift_d = {shift_q, s_sync};
    end

    // Receive FSM. Sample points are H apart (a1, b1, a2, b2, ...) starting at
    // T-H/2, so a running target replaces a k*T multiply. GAP leaves only after
    // a full T-cycle low run plus one further low sample, so a start bit whose
    // low half directly abuts a too-short gap is still ignored.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            samp_q  <= '0;
            half_q  <= 1'b0;
            a_q     <= 1'b0;
            idx_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    gap_q <= '0;
                    if (rise) begin
                        state_q <= ST_START;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ST_START: begin
                    if (cnt_q == START_CHK) begin
                        if (s_sync) begin
                            state_q <= ST_DATA;
                            cnt_q   <= cnt_q + CNT_ONE;
                            samp_q  <= FIRST_SMP;
                            half_q  <= 1'b0;
                            idx_q   <= IDX_ONE;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == samp_q) begin
                        samp_q <= samp_q + SMP_STEP;
                        if (!half_q) begin
                            a_q    <= s_sync;
                            half_q <= 1'b1;
                        end else begin
                            shift_q <= shift_d[FRAME_BITS-2:0];
                            half_q  <= 1'b0;
                            idx_q   <= idx_q + IDX_ONE;
                            if (a_q == s_sync) begin
                                err_q   <= 1'b1;
                                state_q <= ST_GAP;
                                cnt_q   <= '0;
                                gap_q   <= '0;
                            end else if (idx_q == LAST_BIT) begin
                                code_q  <= shift_d;
                                valid_q <= 1'b1;
                                state_q <= ST_GAP;
                                cnt_q   <= '0;
                                gap_q   <= '0;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    cnt_q <= '0;
                    if (s_sync) begin
                        gap_q <= '0;
                    end else if (gap_q == GAP_LEN) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rc5_manchester_rx.sv
// tb/tb_rc5_manchester_rx.sv - directed self-checking bench for rc5_manchester_rx
module tb_rc5_manchester_rx;

    import rc5_pkg::*;

    localparam int H   = 4;
    localparam int T   = 2 * H;
    localparam int FB  = 11;
    localparam int LAT = 93;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          s_in;
    logic [FB-1:0] code;
    logic          valid;
    logic          err;
    logic          busy;

    rc5_manchester_rx #(
        .HALF_BIT_CYCLES (H),
        .FRAME_BITS      (FB)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .s_in  (s_in),
        .code  (code),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int            vq[$];
    logic [FB-1:0] cq[$];
    int            eq[$];
    int            n_overlap = 0;

    always @(negedge clock) begin
        if (valid) begin
            vq.push_back(cyc);
            cq.push_back(code);
        end
        if (err) eq.push_back(cyc);
        if (valid && err) n_overlap++;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int drv_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        @(posedge clock);
        #1;
        s_in    = v;
        drv_cyc = cyc;
        repeat (n - 1) @(posedge clock);
    endtask

    task automatic send_frame(input logic [FB-1:0] data, input int flat_bit, input int nbits,
                              output int rise);
        drive(1'b0, H);
        drive(1'b1, H);
        rise = drv_cyc;
        for (int k = 1; k <= nbits; k++) begin
            if (k == flat_bit) begin
                drive(1'b0, T);
            end else if (data[FB-k]) begin
                drive(1'b0, H);
                drive(1'b1, H);
            end else begin
                drive(1'b1, H);
                drive(1'b0, H);
            end
        end
    endtask

    task automatic clear_logs();
        vq.delete();
        cq.delete();
        eq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, r2, r3, bcnt;
        rst_n = 1'b0;
        s_in  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_code", code, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        @(posedge clock);
        #1 rst_n = 1'b1;
        drive(1'b0, 10);

        // single frame, latency and value
        send_frame(RC5_CMD_A, 0, FB, r);
        @(negedge clock);
        check("t1_busy_gap", busy, 1);
        drive(1'b0, 30);
        @(negedge clock);
        check("t1_nvalid", vq.size(), 1);
        if (vq.size() > 0) begin
            check("t1_lat", vq[0] - r, LAT);
            check("t1_code", cq[0], RC5_CMD_A);
        end
        check("t1_nerr", eq.size(), 0);
        check("t1_idle", busy, 0);

        // missing mid-bit transition on data bit 5
        clear_logs();
        send_frame(RC5_CMD_B, 5, FB, r);
        @(negedge clock);
        check("t2_busy_gap", busy, 1);
        drive(1'b0, 30);
        @(negedge clock);
        check("t2_nerr", eq.size(), 1);
        if (eq.size() > 0) check("t2_err_time", eq[0] - r, 45);
        check("t2_nvalid", vq.size(), 0);
        check("t2_code_held", code, RC5_CMD_A);
        check("t2_idle", busy, 0);

        // one-cycle glitch on an idle line
        clear_logs();
        drive(1'b1, 1);
        drive(1'b0, 1);
        bcnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (busy) bcnt++;
        end
        check("t3_busy_cycles", bcnt, 2);
        check("t3_nerr", eq.size(), 0);
        check("t3_nvalid", vq.size(), 0);

        // reset in the middle of data bit 6
        send_frame(RC5_CMD_A, 0, 5, r);
        drive(1'b1, H / 2);
        @(negedge clock);
        check("t4_busy_pre", busy, 1);
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        s_in  = 1'b0;
        #1;
        check("t4_code_rst", code, 0);
        check("t4_valid_rst", valid, 0);
        check("t4_err_rst", err, 0);
        check("t4_busy_rst", busy, 0);
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        drive(1'b0, 20);
        check("t4_quiet_err", eq.size(), 0);
        check("t4_quiet_valid", vq.size(), 0);
        send_frame(RC5_CMD_A, 0, FB, r);
        drive(1'b0, 30);
        @(negedge clock);
        check("t4_nvalid", vq.size(), 1);
        if (vq.size() > 0) begin
            check("t4_code", cq[0], RC5_CMD_A);
            check("t4_lat", vq[0] - r, LAT);
        end

        // two frames separated by 2T, second one all zeros
        clear_logs();
        send_frame(RC5_CMD_B, 0, FB, r);
        drive(1'b0, 2 * T);
        send_frame(RC5_CMD_ZERO, 0, FB, r2);
        drive(1'b0, 30);
        @(negedge clock);
        check("t5_nvalid", vq.size(), 2);
        if (vq.size() > 1) begin
            check("t5_code0", cq[0], RC5_CMD_B);
            check("t5_code1", cq[1], RC5_CMD_ZERO);
            check("t5_lat0", vq[0] - r, LAT);
            check("t5_lat1", vq[1] - r2, LAT);
        end
        check("t5_nerr", eq.size(), 0);
        check("t5_code_now", code, RC5_CMD_ZERO);

        // frame started only H after the previous one is dropped
        clear_logs();
        send_frame(RC5_CMD_A, 0, FB, r);
        drive(1'b0, H);
        send_frame(RC5_CMD_B, 0, FB, r2);
        drive(1'b0, 30);
        send_frame(RC5_CMD_C, 0, FB, r3);
        drive(1'b0, 30);
        @(negedge clock);
        check("t6_nvalid", vq.size(), 2);
        if (vq.size() > 1) begin
            check("t6_code0", cq[0], RC5_CMD_A);
            check("t6_code1", cq[1], RC5_CMD_C);
            check("t6_lat1", vq[1] - r3, LAT);
        end
        check("t6_nerr", eq.size(), 0);

        check("valid_err_overlap", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
